// File: rtl/partition_error_monitor.sv
// -----------------------------------------------------------------------------
// partition_error_monitor
//
// Sweeps every input vector 0..2^IN_W-1 into an exact and an approximate
// partition that sit side by side, samples both responses and accumulates
// error metrics on chip: mismatch count, Hamming sum, absolute-error sum,
// maximum absolute error and the index of the first failing vector.
//
// Parameters
//   IN_W   partition input width; a sweep is 2^IN_W vectors
//   OUT_W  partition output width; outputs compared as unsigned integers
//   LAT    pipeline latency of the partition pair in cycles (0 = combinational)
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   start           pulse; begins a sweep from IDLE or DONE, ignored while busy
//   pi              stimulus vector driven to both partitions
//   pi_valid        pi is a live sweep vector this cycle
//   po_exact        exact partition output
//   po_approx       approximate partition output
//   busy            sweep or drain in progress
//   done            sweep finished; all results final and held
//   err_cnt         number of vectors with po_exact != po_approx
//   ham_sum         total number of differing output bits
//   abs_err_sum     sum of |po_exact - po_approx|
//   max_err         largest |po_exact - po_approx|
//   first_fail_idx  pi of the first mismatching vector of the sweep
//   first_fail_vld  at least one mismatch seen in the sweep
// -----------------------------------------------------------------------------
module partition_error_monitor #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4,
  parameter int LAT   = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic [IN_W-1:0]                   pi,
  output logic                              pi_valid,
  input  logic [OUT_W-1:0]                  po_exact,
  input  logic [OUT_W-1:0]                  po_approx,
  output logic                              busy,
  output logic                              done,
  output logic [IN_W:0]                     err_cnt,
  output logic [IN_W+$clog2(OUT_W+1)-1:0]   ham_sum,
  output logic [IN_W+OUT_W-1:0]             abs_err_sum,
  output logic [OUT_W-1:0]                  max_err,
  output logic [IN_W-1:0]                   first_fail_idx,
  output logic                              first_fail_vld
);

  localparam int POP_W = $clog2(OUT_W + 1);
  localparam int CNT_W = IN_W + 1;
  localparam int HAM_W = IN_W + POP_W;
  localparam int ABS_W = IN_W + OUT_W;
  localparam int DW    = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = (LAT > 0) ? DW'(LAT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [DW-1:0]   drain_cnt;
  logic            last_vec;
  logic            launch;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  assign last_vec = (pi == {IN_W{1'b1}});
  // A new sweep only launches from a quiet state; start while busy is dropped.
  assign launch   = start && ((state == IDLE) || (state == DONE));

  assign pi_valid = (state == SWEEP);
  assign busy     = (state == SWEEP) || (state == DRAIN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:  if (launch) state_next = SWEEP;
      SWEEP: if (last_vec) state_next = (LAT == 0) ? DONE : DRAIN;
      DRAIN: if (drain_cnt == DRAIN_LAST) state_next = DONE;
      DONE:  if (launch) state_next = SWEEP;
      default: state_next = IDLE;
    endcase
  end

  // Stimulus counter; holds its last value through DRAIN and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pi <= '0;
    end else if (launch) begin
      pi <= '0;
    end else if ((state == SWEEP) && !last_vec) begin
      pi <= pi + IN_W'(1);
    end
  end

  // Counts the LAT cycles spent waiting for in-flight responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (state == DRAIN) begin
      drain_cnt <= drain_cnt + DW'(1);
    end else begin
      drain_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Response alignment: delay valid and index by the partition latency so a
  // sample is always tagged with the vector that produced it.
  // ---------------------------------------------------------------------------
  logic            rsp_valid;
  logic [IN_W-1:0] rsp_idx;

  generate
    if (LAT == 0) begin : g_no_delay
      assign rsp_valid = pi_valid;
      assign rsp_idx   = pi;
    end else begin : g_delay
      logic [LAT-1:0]  vld_sr;
      logic [IN_W-1:0] idx_sr [LAT];

      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this small shift register is reset (unlike a RAM would be) so
        // no phantom samples emerge after a mid-sweep reset.
        if (!rst_n) begin
          vld_sr <= '0;
          for (int i = 0; i < LAT; i++) idx_sr[i] <= '0;
        end else begin
          vld_sr[0] <= pi_valid;
          idx_sr[0] <= pi;
          for (int i = 1; i < LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            idx_sr[i] <= idx_sr[i-1];
          end
        end
      end

      assign rsp_valid = vld_sr[LAT-1];
      assign rsp_idx   = idx_sr[LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-sample error terms
  // ---------------------------------------------------------------------------
  function automatic logic [POP_W-1:0] popcount(input logic [OUT_W-1:0] x);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < OUT_W; i++) n = n + POP_W'(x[i]);
    return n;
  endfunction

  logic [OUT_W:0]   diff_wide;
  logic [OUT_W:0]   abs_d;
  logic [POP_W-1:0] ham_d;
  logic             mismatch;

  // One extra bit captures the borrow, which selects the sign correction.
  assign diff_wide = {1'b0, po_exact} - {1'b0, po_approx};
  assign abs_d     = diff_wide[OUT_W] ? (~diff_wide + 1'b1) : diff_wide;
  assign ham_d     = popcount(po_exact ^ po_approx);
  assign mismatch  = (po_exact != po_approx);

  // ---------------------------------------------------------------------------
  // Accumulators: cleared on launch, updated the cycle after each sample.
  // Widths cover a full sweep of worst-case errors, so no saturation needed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      ham_sum        <= '0;
      abs_err_sum    <= '0;
      max_err        <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (launch) begin
      err_cnt        <= '0;
      ham_sum        <= '0;
      abs_err_sum    <= '0;
      max_err        <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (rsp_valid) begin
      ham_sum     <= ham_sum + HAM_W'(ham_d);
      abs_err_sum <= abs_err_sum + ABS_W'(abs_d);
      if (abs_d > {1'b0, max_err}) max_err <= abs_d[OUT_W-1:0];
      if (mismatch) begin
        err_cnt <= err_cnt + CNT_W'(1);
        // Only the first mismatch of a sweep is recorded.
        if (!first_fail_vld) begin
          first_fail_idx <= rsp_idx;
          first_fail_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_partition_error_monitor.sv
// -----------------------------------------------------------------------------
// tb_partition_error_monitor
//
// Directed bench for partition_error_monitor. Two monitors are instantiated:
// one against a combinational partition pair (LAT=0) and one against a pair
// registered for two cycles (LAT=2). The partition pair is modelled here as
// exact = pi[3:0] and an approximate output chosen by 'mode'.
// -----------------------------------------------------------------------------
module tb_partition_error_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // Combinational-latency instance
  logic       start0 = 1'b0;
  logic [6:0] pi0;
  logic       pv0, busy0, done0, ffv0;
  logic [3:0] pe0, pa0, maxe0;
  logic [7:0] err0;
  logic [9:0] ham0;
  logic [10:0] abs0;
  logic [6:0] ffi0;

  // Two-cycle-latency instance
  logic       start1 = 1'b0;
  logic [6:0] pi1;
  logic       pv1, busy1, done1, ffv1;
  logic [3:0] pe1, pa1, maxe1;
  logic [7:0] err1;
  logic [9:0] ham1;
  logic [10:0] abs1;
  logic [6:0] ffi1;

  function automatic logic [3:0] f_exact(input logic [6:0] p);
    return p[3:0];
  endfunction

  // mode 0: identical, 1: LSB flipped, 2: stuck at zero,
  // 3: two isolated errors at pi=37 and pi=90 (nibble ^ 4'b0110)
  function automatic logic [3:0] f_approx(input logic [6:0] p, input int m);
    case (m)
      1:       return p[3:0] ^ 4'b0001;
      2:       return 4'b0000;
      3:       return ((p == 7'd37) || (p == 7'd90)) ? (p[3:0] ^ 4'b0110) : p[3:0];
      default: return p[3:0];
    endcase
  endfunction

  assign pe0 = f_exact(pi0);
  assign pa0 = f_approx(pi0, mode);

  // Registered partition pair: two flops of input delay in front of the logic.
  logic [6:0] p1_d1, p1_d2;
  always @(posedge clk) begin
    p1_d1 <= pi1;
    p1_d2 <= p1_d1;
  end
  assign pe1 = f_exact(p1_d2);
  assign pa1 = f_approx(p1_d2, mode);

  partition_error_monitor #(.IN_W(7), .OUT_W(4), .LAT(0)) u_dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start0),
    .pi             (pi0),
    .pi_valid       (pv0),
    .po_exact       (pe0),
    .po_approx      (pa0),
    .busy           (busy0),
    .done           (done0),
    .err_cnt        (err0),
    .ham_sum        (ham0),
    .abs_err_sum    (abs0),
    .max_err        (maxe0),
    .first_fail_idx (ffi0),
    .first_fail_vld (ffv0)
  );

  partition_error_monitor #(.IN_W(7), .OUT_W(4), .LAT(2)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start1),
    .pi             (pi1),
    .pi_valid       (pv1),
    .po_exact       (pe1),
    .po_approx      (pa1),
    .busy           (busy1),
    .done           (done1),
    .err_cnt        (err1),
    .ham_sum        (ham1),
    .abs_err_sum    (abs1),
    .max_err        (maxe1),
    .first_fail_idx (ffi1),
    .first_fail_vld (ffv1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start on the chosen instance and follows the sweep until done.
  // inject_at >= 0 re-pulses start that many cycles into the sweep.
  // n_valid counts pi_valid cycles; gap is the cycle distance from the last
  // pi_valid cycle to the first done cycle.
  task automatic run_sweep(input int inst, input int inject_at,
                           output int n_valid, output int gap);
    int  last_v;
    bit  seen_done;
    last_v    = -1;
    seen_done = 1'b0;
    n_valid   = 0;
    gap       = -1;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    for (int c = 0; c < 400 && !seen_done; c++) begin
      @(negedge clk);
      if (inst == 0) start0 = (c == inject_at); else start1 = (c == inject_at);
      if ((inst == 0) ? pv0 : pv1) begin
        n_valid++;
        last_v = c;
      end
      if ((inst == 0) ? done0 : done1) begin
        gap       = c - last_v;
        seen_done = 1'b1;
      end
    end
    start0 = 1'b0;
    start1 = 1'b0;
    check("done_reached", 32'(seen_done), 32'd1);
  endtask

  task automatic check_results(input string tag, input int inst,
                               input int e_cnt, input int e_ham, input int e_abs,
                               input int e_max, input int e_idx, input int e_vld);
    if (inst == 0) begin
      check({tag, ".err_cnt"},        32'(err0),  32'(e_cnt));
      check({tag, ".ham_sum"},        32'(ham0),  32'(e_ham));
      check({tag, ".abs_err_sum"},    32'(abs0),  32'(e_abs));
      check({tag, ".max_err"},        32'(maxe0), 32'(e_max));
      check({tag, ".first_fail_vld"}, 32'(ffv0),  32'(e_vld));
      if (e_vld != 0) check({tag, ".first_fail_idx"}, 32'(ffi0), 32'(e_idx));
    end else begin
      check({tag, ".err_cnt"},        32'(err1),  32'(e_cnt));
      check({tag, ".ham_sum"},        32'(ham1),  32'(e_ham));
      check({tag, ".abs_err_sum"},    32'(abs1),  32'(e_abs));
      check({tag, ".max_err"},        32'(maxe1), 32'(e_max));
      check({tag, ".first_fail_vld"}, 32'(ffv1),  32'(e_vld));
      if (e_vld != 0) check({tag, ".first_fail_idx"}, 32'(ffi1), 32'(e_idx));
    end
  endtask

  task automatic check_all_zero0(input string tag);
    check({tag, ".pi"},             32'(pi0),   32'd0);
    check({tag, ".pi_valid"},       32'(pv0),   32'd0);
    check({tag, ".busy"},           32'(busy0), 32'd0);
    check({tag, ".done"},           32'(done0), 32'd0);
    check({tag, ".err_cnt"},        32'(err0),  32'd0);
    check({tag, ".ham_sum"},        32'(ham0),  32'd0);
    check({tag, ".abs_err_sum"},    32'(abs0),  32'd0);
    check({tag, ".max_err"},        32'(maxe0), 32'd0);
    check({tag, ".first_fail_idx"}, 32'(ffi0),  32'd0);
    check({tag, ".first_fail_vld"}, 32'(ffv0),  32'd0);
  endtask

  initial begin
    int nv, gap;
    bit hit40;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero0("rst");
    check("rst.busy1", 32'(busy1), 32'd0);
    check("rst.done1", 32'(done1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Exact == approx
    mode = 0;
    run_sweep(0, -1, nv, gap);
    check("eq.n_valid", 32'(nv), 32'd128);
    check("eq.gap", 32'(gap), 32'd1);
    check_results("eq", 0, 0, 0, 0, 0, 0, 0);

    // LSB flipped on every vector
    mode = 1;
    run_sweep(0, -1, nv, gap);
    check_results("lsb", 0, 128, 128, 128, 1, 0, 1);

    // Approx stuck at zero
    mode = 2;
    run_sweep(0, -1, nv, gap);
    check("zero.n_valid", 32'(nv), 32'd128);
    check_results("zero", 0, 120, 256, 960, 15, 1, 1);

    // Two isolated errors: first must stay at 37
    mode = 3;
    run_sweep(0, -1, nv, gap);
    check_results("sparse", 0, 2, 4, 4, 2, 37, 1);

    // Two-cycle registered pair, stuck-at-zero data
    mode = 2;
    run_sweep(1, -1, nv, gap);
    check("lat2.n_valid", 32'(nv), 32'd128);
    check("lat2.gap", 32'(gap), 32'd3);
    check_results("lat2", 1, 120, 256, 960, 15, 1, 1);

    // start pulsed mid-sweep is ignored
    mode = 2;
    run_sweep(0, 20, nv, gap);
    check("midstart.n_valid", 32'(nv), 32'd128);
    check_results("midstart", 0, 120, 256, 960, 15, 1, 1);

    // Reset at pi=40 during a sweep
    mode  = 2;
    hit40 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int c = 0; c < 200 && !hit40; c++) begin
      if (pi0 == 7'd40) hit40 = 1'b1;
      else @(negedge clk);
    end
    check("rst40.reached", 32'(hit40), 32'd1);
    check("rst40.busy_before", 32'(busy0), 32'd1);
    rst_n = 1'b0;
    #2;
    check_all_zero0("rst40");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, -1, nv, gap);
    check("after_rst.n_valid", 32'(nv), 32'd128);
    check_results("after_rst", 0, 120, 256, 960, 15, 1, 1);

    // Restart from DONE with matching outputs clears everything
    mode = 0;
    run_sweep(0, -1, nv, gap);
    check_results("restart0", 0, 0, 0, 0, 0, 0, 0);
    run_sweep(1, -1, nv, gap);
    check("restart1.gap", 32'(gap), 32'd3);
    check_results("restart1", 1, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
